picoblaze_outreg_bank: RTL

Parametrised bank of 8-bit PicoBlaze output registers at consecutive port IDs. It replaces single-register output ports with one block that supports:
- write, set-bits, clear-bits and toggle-bits operations selected by port ID;
- per-register auto-clearing pulse mode;
- combinational readback through the PicoBlaze input mux.

It sits between the PicoBlaze port bus and board peripherals (LEDs, enables, strobes).

---
 rtl/picoblaze_io_pkg.sv | 50 +++++
 rtl/picoblaze_pulse_timer.sv | 27 ++
 rtl/picoblaze_outreg_bank.sv | 84 ++++++++
 3 files changed

// File: rtl/picoblaze_io_pkg.sv
// Shared PicoBlaze port-bus definitions: port-ID op encoding, the register op ALU
// and parameter legality checks used at elaboration.
package picoblaze_io_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_SET   = 2'b01,
        OP_CLR   = 2'b10,
        OP_TGL   = 2'b11
    } op_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic logic [7:0] apply_op(input op_e op, input logic [7:0] cur,
                                            input logic [7:0] data);
        logic [7:0] result;
        result = cur;
        case (op)
            OP_WRITE: result = data;
            OP_SET:   result = cur | data;
            OP_CLR:   result = cur & ~data;
            OP_TGL:   result = cur ^ data;
            default:  result = cur;
        endcase
        return result;
    endfunction

    function automatic bit num_regs_legal(input int unsigned num_regs);
        return (num_regs == 2) || (num_regs == 4) || (num_regs == 8) || (num_regs == 16);
    endfunction

    // The op and index fields occupy the low IDX_W+2 bits, so those must be zero in the base.
    function automatic bit base_aligned(input logic [7:0] base, input int unsigned idx_w);
        logic [7:0] mask;
        mask = 8'((32'd1 << (idx_w + 2)) - 32'd1);
        return (base & mask) == 8'h00;
    endfunction

    function automatic bit pulse_cycles_legal(input int unsigned cycles);
        return (cycles >= 1) && (cycles <= 255);
    endfunction

endpackage

// File: rtl/picoblaze_pulse_timer.sv
// Reload/decrement counter that flags the last cycle of a pulse-mode register.
module picoblaze_pulse_timer
    import picoblaze_io_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_value,
    output logic       expire
);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_value;
        end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    // A reload in the same cycle overrides expiry.
    assign expire = (cnt == 8'd1) && !load;

endmodule

// File: rtl/picoblaze_outreg_bank.sv
// Bank of 8-bit PicoBlaze output registers with write/set/clear/toggle aliases,
// optional auto-clearing pulse mode and combinational readback.
module picoblaze_outreg_bank
    import picoblaze_io_pkg::*;
#(
    parameter int unsigned          NUM_REGS     = 4,
    parameter logic [7:0]           BASE_PORT_ID = 8'h40,
    parameter logic [NUM_REGS-1:0]  PULSE_REGS   = '0,
    parameter int unsigned          PULSE_CYCLES = 4,
    parameter logic [7:0]           RESET_VALUE  = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            port_id,
    input  logic                  write_strobe,
    input  logic [7:0]            out_port,
    output logic [8*NUM_REGS-1:0] regs_out,
    output logic [NUM_REGS-1:0]   reg_written,
    output logic [7:0]            in_port_data,
    output logic                  in_port_hit
);

    localparam int unsigned IDX_W = clog2(NUM_REGS);

    if (!num_regs_legal(NUM_REGS)) begin : g_bad_num_regs
        $error("picoblaze_outreg_bank: NUM_REGS must be 2, 4, 8 or 16");
    end
    if (!base_aligned(BASE_PORT_ID, IDX_W)) begin : g_bad_base
        $error("picoblaze_outreg_bank: BASE_PORT_ID low IDX_W+2 bits must be zero");
    end
    if (!pulse_cycles_legal(PULSE_CYCLES)) begin : g_bad_pulse
        $error("picoblaze_outreg_bank: PULSE_CYCLES must be in 1..255");
    end

    logic             hit;
    logic [IDX_W-1:0] idx;
    op_e              op;

    assign hit = (port_id[7:IDX_W+2] == BASE_PORT_ID[7:IDX_W+2]);
    assign idx = port_id[IDX_W-1:0];
    assign op  = op_e'(port_id[IDX_W+1:IDX_W]);

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        logic       wr;
        logic       expire;
        logic [7:0] q;
        logic       written_q;

        assign wr = write_strobe && hit && (idx == IDX_W'(i));

        if (PULSE_REGS[i]) begin : g_pulse
            picoblaze_pulse_timer u_timer (
                .clk        (clk),
                .reset      (reset),
                .load       (wr),
                .load_value (8'(PULSE_CYCLES)),
                .expire     (expire)
            );
        end else begin : g_static
            assign expire = 1'b0;
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                q         <= RESET_VALUE;
                written_q <= 1'b0;
            end else begin
                written_q <= wr;
                if (wr) begin
                    q <= apply_op(op, q, out_port);
                end else if (expire) begin
                    q <= '0;
                end
            end
        end

        assign regs_out[8*i +: 8] = q;
        assign reg_written[i]     = written_q;
    end

    assign in_port_hit  = hit;
    assign in_port_data = hit ? regs_out[{idx, 3'b000} +: 8] : '0;

endmodule
